sram_access_arbiter: RTL and testbench

- Shares the single external 18-bit-address, 16-bit-data SRAM port between the Milestone 1 engine (upsampling/colour conversion) and the Milestone 2 engine (IDCT pre-IDCT fetch and post-IDCT write-back).
- Grants one owner at a time, round-robin with a burst cap.
- Registers the SRAM address, write data and write enable.
- Tags each in-flight read so returned data is flagged valid only to the requester that issued it.
- Sits between the milestone engines and the top-level SRAM controller.

---
 rtl/sram_access_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM port between the M1 and M2 engines, one owner at a time, round-robin with a burst cap.
// Latency: an accepted command reaches the SRAM pins one edge later; its read data is flagged valid READ_LATENCY+1 cycles after acceptance.
// Backpressure: a requester holds req until granted; an owner change costs one dead cycle; the burst cap only bites under contention.
module sram_access_arbiter #(
    parameter int ADDRESS_WIDTH = 18,
    parameter int DATA_WIDTH    = 16,
    parameter int READ_LATENCY  = 2,
    parameter int MAX_BURST     = 64
) (
    input  logic                     Clock,
    input  logic                     Resetn,

    input  logic                     M1_req,
    input  logic [ADDRESS_WIDTH-1:0] M1_address,
    input  logic [DATA_WIDTH-1:0]    M1_write_data,
    input  logic                     M1_we_n,
    output logic                     M1_grant,
    output logic [DATA_WIDTH-1:0]    M1_read_data,
    output logic                     M1_read_valid,

    input  logic                     M2_req,
    input  logic [ADDRESS_WIDTH-1:0] M2_address,
    input  logic [DATA_WIDTH-1:0]    M2_write_data,
    input  logic                     M2_we_n,
    output logic                     M2_grant,
    output logic [DATA_WIDTH-1:0]    M2_read_data,
    output logic                     M2_read_valid,

    output logic [ADDRESS_WIDTH-1:0] SRAM_address,
    output logic [DATA_WIDTH-1:0]    SRAM_write_data,
    output logic                     SRAM_we_n,
    input  logic [DATA_WIDTH-1:0]    SRAM_read_data
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW:0]   BURST_LIM = (BCW + 1)'(MAX_BURST);
    localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, GRANT_M1, GRANT_M2, SWITCH} state_t;
    typedef enum logic {OWNER_M1 = 1'b0, OWNER_M2 = 1'b1} owner_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    write_data;
        logic                     we_n;
    } sram_cmd_t;

    typedef struct packed {
        logic   vld;
        owner_t id;
    } rd_tag_t;

    state_t         state, state_nxt;
    owner_t         last_owner, last_owner_nxt;
    owner_t         cur_owner;
    logic [BCW-1:0] burst_count, burst_count_nxt, burst_sat;
    logic [BCW:0]   burst_inc;
    logic           burst_last;
    logic           own_req, other_req;
    logic           accept_m1, accept_m2, accept;
    sram_cmd_t      m1_cmd, m2_cmd, acc_cmd;
    rd_tag_t        tag_in;
    rd_tag_t        tag_pipe [READ_LATENCY];

    assign m1_cmd    = '{address: M1_address, write_data: M1_write_data, we_n: M1_we_n};
    assign m2_cmd    = '{address: M2_address, write_data: M2_write_data, we_n: M2_we_n};

    assign accept_m1 = (state == GRANT_M1) && M1_req;
    assign accept_m2 = (state == GRANT_M2) && M2_req;
    assign accept    = accept_m1 || accept_m2;
    assign acc_cmd   = accept_m2 ? m2_cmd : m1_cmd;

    assign cur_owner = (state == GRANT_M2) ? OWNER_M2 : OWNER_M1;
    assign own_req   = (state == GRANT_M2) ? M2_req : M1_req;
    assign other_req = (state == GRANT_M2) ? M1_req : M2_req;

    // burst_last flags the accept that uses up the tenure; the count itself saturates at the cap
    assign burst_inc  = {1'b0, burst_count} + {{BCW{1'b0}}, 1'b1};
    assign burst_last = burst_inc >= BURST_LIM;
    assign burst_sat  = burst_last ? BURST_MAX : burst_inc[BCW-1:0];

    assign M1_grant     = (state == GRANT_M1);
    assign M2_grant     = (state == GRANT_M2);
    assign M1_read_data = SRAM_read_data;
    assign M2_read_data = SRAM_read_data;

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        unique case (state)
            IDLE: begin
                if (M1_req && M2_req) begin
                    state_nxt = (last_owner == OWNER_M2) ? GRANT_M1 : GRANT_M2;
                end else if (M1_req) begin
                    state_nxt = GRANT_M1;
                end else if (M2_req) begin
                    state_nxt = GRANT_M2;
                end
            end
            GRANT_M1, GRANT_M2: begin
                if (!own_req || (burst_last && other_req)) begin
                    state_nxt      = other_req ? SWITCH : IDLE;
                    last_owner_nxt = cur_owner;
                end
            end
            SWITCH: begin
                // the side that did not just own the port gets first refusal
                if (last_owner == OWNER_M1) begin
                    if (M2_req)      state_nxt = GRANT_M2;
                    else if (M1_req) state_nxt = GRANT_M1;
                    else             state_nxt = IDLE;
                end else begin
                    if (M1_req)      state_nxt = GRANT_M1;
                    else if (M2_req) state_nxt = GRANT_M2;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        burst_count_nxt = burst_count;
        if ((state == IDLE || state == SWITCH) &&
            (state_nxt == GRANT_M1 || state_nxt == GRANT_M2)) begin
            burst_count_nxt = '0;
        end else if (accept) begin
            burst_count_nxt = burst_sat;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            last_owner  <= OWNER_M2;
            burst_count <= '0;
        end else begin
            state       <= state_nxt;
            last_owner  <= last_owner_nxt;
            burst_count <= burst_count_nxt;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
        end else if (accept) begin
            SRAM_address    <= acc_cmd.address;
            SRAM_write_data <= acc_cmd.write_data;
            SRAM_we_n       <= acc_cmd.we_n;
        end else begin
            SRAM_we_n       <= 1'b1;
        end
    end

    // one tag per edge keeps each read aligned with its data, across owner changes
    assign tag_in = '{vld: accept && acc_cmd.we_n, id: accept_m2 ? OWNER_M2 : OWNER_M1};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            M1_read_valid <= 1'b0;
            M2_read_valid <= 1'b0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            M1_read_valid <= tag_pipe[READ_LATENCY-1].vld && (tag_pipe[READ_LATENCY-1].id == OWNER_M1);
            M2_read_valid <= tag_pipe[READ_LATENCY-1].vld && (tag_pipe[READ_LATENCY-1].id == OWNER_M2);
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_sram_access_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int MB = 4;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          M1_req = 1'b0, M1_we_n = 1'b1, M1_grant, M1_read_valid;
    logic [AW-1:0] M1_address = '0;
    logic [DW-1:0] M1_write_data = '0, M1_read_data;
    logic          M2_req = 1'b0, M2_we_n = 1'b1, M2_grant, M2_read_valid;
    logic [AW-1:0] M2_address = '0;
    logic [DW-1:0] M2_write_data = '0, M2_read_data;
    logic [AW-1:0] SRAM_address;
    logic [DW-1:0] SRAM_write_data;
    logic          SRAM_we_n;
    logic [DW-1:0] SRAM_read_data;

    sram_access_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .M1_req(M1_req), .M1_address(M1_address), .M1_write_data(M1_write_data), .M1_we_n(M1_we_n),
        .M1_grant(M1_grant), .M1_read_data(M1_read_data), .M1_read_valid(M1_read_valid),
        .M2_req(M2_req), .M2_address(M2_address), .M2_write_data(M2_write_data), .M2_we_n(M2_we_n),
        .M2_grant(M2_grant), .M2_read_data(M2_read_data), .M2_read_valid(M2_read_valid),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .SRAM_read_data(SRAM_read_data)
    );

    always #5 Clock = ~Clock;

    typedef struct { int stamp; logic g1; logic g2; } gnt_e;
    typedef struct { int stamp; logic [AW-1:0] addr; logic [DW-1:0] data; logic we_n; } bus_e;
    typedef struct { int stamp; logic [DW-1:0] data; } rd_e;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic we_n; } txn_t;

    gnt_e gq[$];
    bus_e bq[$];
    rd_e  rq1[$], rq2[$];
    txn_t tx1[$], tx2[$];
    bit   en1, en2, mon_en;
    int   total, bad, cyc;
    int   own, prev, run_len;  // own: 0 none, 1 M1, 2 M2, 3 dead cycle; prev: last owner
    gnt_e g_cur;
    bus_e b_cur;
    rd_e  r_cur;
    logic exp_v1, exp_v2;
    logic [AW-1:0] a_d1;

    function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], 14'h0A5C};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM device: data for the address presented after edge k appears after edge k+2
    always @(posedge Clock) begin
        cyc            <= cyc + 1;
        a_d1           <= SRAM_address;
        SRAM_read_data <= pat(a_d1);
    end

    always @(negedge Clock) begin
        if (mon_en) begin
            if (gq.size() > 0 && gq[0].stamp == cyc) begin
                g_cur = gq.pop_front();
                check("m1_grant", 32'(M1_grant), 32'(g_cur.g1));
                check("m2_grant", 32'(M2_grant), 32'(g_cur.g2));
            end
            if (bq.size() > 0 && bq[0].stamp == cyc) begin
                b_cur = bq.pop_front();
                check("sram_address", 32'(SRAM_address), 32'(b_cur.addr));
                check("sram_we_n", 32'(SRAM_we_n), 32'(b_cur.we_n));
                if (!b_cur.we_n) check("sram_write_data", 32'(SRAM_write_data), 32'(b_cur.data));
            end else begin
                check("idle_we_n", 32'(SRAM_we_n), 32'd1);
            end
            exp_v1 = (rq1.size() > 0 && rq1[0].stamp == cyc);
            exp_v2 = (rq2.size() > 0 && rq2[0].stamp == cyc);
            check("m1_read_valid", 32'(M1_read_valid), 32'(exp_v1));
            check("m2_read_valid", 32'(M2_read_valid), 32'(exp_v2));
            if (exp_v1) begin
                r_cur = rq1.pop_front();
                if (M1_read_valid) check("m1_read_data", 32'(M1_read_data), 32'(r_cur.data));
            end
            if (exp_v2) begin
                r_cur = rq2.pop_front();
                if (M2_read_valid) check("m2_read_data", 32'(M2_read_data), 32'(r_cur.data));
            end
        end
    end

    task automatic do_accept(int m);
        txn_t t;
        rd_e  r;
        bus_e b;
        if (m == 1) t = tx1.pop_front();
        else        t = tx2.pop_front();
        b.stamp = cyc + 1; b.addr = t.addr; b.data = t.data; b.we_n = t.we_n;
        bq.push_back(b);
        if (t.we_n) begin
            r.stamp = cyc + 1 + RL;
            r.data  = pat(t.addr);
            if (m == 1) rq1.push_back(r);
            else        rq2.push_back(r);
        end
    endtask

    // Reference arbitration: who owns the port this cycle, and who owns it next.
    task automatic model_step(bit r1, bit r2);
        gnt_e g;
        int   nxt;
        bit   ro, rx;
        g.stamp = cyc; g.g1 = (own == 1); g.g2 = (own == 2);
        gq.push_back(g);
        nxt = own;
        if (own == 0) begin
            if (r1 && r2)  nxt = 3 - prev;
            else if (r1)   nxt = 1;
            else if (r2)   nxt = 2;
        end else if (own == 3) begin
            if (((3 - prev) == 1) ? r1 : r2) nxt = 3 - prev;
            else if ((prev == 1) ? r1 : r2)  nxt = prev;
            else                             nxt = 0;
        end else begin
            ro = (own == 1) ? r1 : r2;
            rx = (own == 1) ? r2 : r1;
            if (ro) begin
                do_accept(own);
                run_len = (run_len < MB) ? run_len + 1 : MB;
            end
            if (!ro || (run_len >= MB && rx)) begin
                prev = own;
                nxt  = rx ? 3 : 0;
            end
        end
        if (nxt != own && (nxt == 1 || nxt == 2)) run_len = 0;
        own = nxt;
    endtask

    task automatic gen(int m, int n);
        txn_t t;
        for (int i = 0; i < n; i++) begin
            t.addr = 18'($urandom_range(0, 63)) | (($urandom_range(0, 1) == 1) ? 18'h3FFC0 : 18'h0);
            t.data = 16'($urandom);
            t.we_n = 1'($urandom_range(0, 1));
            if (m == 1) tx1.push_back(t);
            else        tx2.push_back(t);
        end
    endtask

    task automatic push_txn(int m, int addr, int data, bit we_n);
        txn_t t;
        t.addr = 18'(addr); t.data = 16'(data); t.we_n = we_n;
        if (m == 1) tx1.push_back(t);
        else        tx2.push_back(t);
    endtask

    task automatic run(int n, bit rnd);
        bit r1, r2;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                if (tx1.size() == 0 && $urandom_range(0, 99) < 30) gen(1, $urandom_range(1, 6));
                if (tx2.size() == 0 && $urandom_range(0, 99) < 30) gen(2, $urandom_range(1, 6));
                en1 = ($urandom_range(0, 99) < 85);
                en2 = ($urandom_range(0, 99) < 85);
            end
            r1 = en1 && tx1.size() > 0;
            r2 = en2 && tx2.size() > 0;
            M1_req = r1;
            M2_req = r2;
            if (r1) begin
                M1_address = tx1[0].addr; M1_write_data = tx1[0].data; M1_we_n = tx1[0].we_n;
            end else begin
                M1_address = 18'($urandom); M1_write_data = 16'($urandom); M1_we_n = 1'($urandom);
            end
            if (r2) begin
                M2_address = tx2[0].addr; M2_write_data = tx2[0].data; M2_we_n = tx2[0].we_n;
            end else begin
                M2_address = 18'($urandom); M2_write_data = 16'($urandom); M2_we_n = 1'($urandom);
            end
            model_step(r1, r2);
            @(posedge Clock);
            #1;
        end
    endtask

    // Asserts reset mid-cycle and checks the asynchronous response before any clock edge.
    task automatic do_reset();
        mon_en = 0;
        M1_req = 1'b0; M2_req = 1'b0; en1 = 0; en2 = 0;
        #2 Resetn = 1'b0;
        #1;
        check("rst_m1_grant", 32'(M1_grant), 32'd0);
        check("rst_m2_grant", 32'(M2_grant), 32'd0);
        check("rst_m1_read_valid", 32'(M1_read_valid), 32'd0);
        check("rst_m2_read_valid", 32'(M2_read_valid), 32'd0);
        check("rst_sram_address", 32'(SRAM_address), 32'd0);
        check("rst_sram_write_data", 32'(SRAM_write_data), 32'd0);
        check("rst_sram_we_n", 32'(SRAM_we_n), 32'd1);
        tx1.delete(); tx2.delete(); gq.delete(); bq.delete(); rq1.delete(); rq2.delete();
        own = 0; prev = 2; run_len = 0;
        @(posedge Clock);
        @(posedge Clock);
        #3 Resetn = 1'b1;
        @(posedge Clock);
        #1;
        mon_en = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; mon_en = 0; own = 0; prev = 2; run_len = 0;
        repeat (2) @(posedge Clock);
        #1;
        do_reset();

        // single M1 stream of reads
        for (int i = 0; i < 8; i++) push_txn(1, 76800 + i, 0, 1'b1);
        en1 = 1;
        run(16, 0);

        // both request from reset: M1 first, M2 after one dead cycle
        do_reset();
        for (int i = 0; i < 3; i++) push_txn(1, 100 + i, 16'hA000 + i, 1'b0);
        for (int i = 0; i < 3; i++) push_txn(2, 200 + i, 0, 1'b1);
        en1 = 1; en2 = 1;
        run(14, 0);

        // burst cap alternates ownership under sustained contention
        do_reset();
        for (int i = 0; i < 10; i++) push_txn(1, 300 + i, 16'hB000 + i, i[0]);
        for (int i = 0; i < 10; i++) push_txn(2, 400 + i, 16'hC000 + i, ~i[0]);
        en1 = 1; en2 = 1;
        run(40, 0);

        // reads in flight across an owner change, then an M2 write
        do_reset();
        push_txn(1, 500, 0, 1'b1);
        push_txn(1, 501, 0, 1'b1);
        push_txn(2, 38400, 16'h1234, 1'b0);
        en1 = 1; en2 = 1;
        run(12, 0);

        // a one-cycle M2 pulse while M1 owns must not steal the port
        do_reset();
        for (int i = 0; i < 10; i++) push_txn(1, 600 + i, 0, 1'b1);
        en1 = 1;
        run(2, 0);
        push_txn(2, 700, 16'h5555, 1'b0);
        en2 = 1;
        run(1, 0);
        en2 = 0;
        tx2.delete();
        run(14, 0);

        // reset while reads are in flight: they must never come back
        do_reset();
        push_txn(1, 800, 0, 1'b1);
        push_txn(1, 801, 0, 1'b1);
        en1 = 1;
        run(4, 0);
        do_reset();
        run(8, 0);

        // random traffic
        do_reset();
        run(3000, 1);
        en1 = 1; en2 = 1;
        for (int i = 0; i < 500 && (tx1.size() + tx2.size()) > 0; i++) run(1, 0);
        check("drain_requests", 32'(tx1.size() + tx2.size()), 32'd0);
        run(RL + 4, 0);
        check("drain_bus", 32'(bq.size()), 32'd0);
        check("drain_reads", 32'(rq1.size() + rq2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
